// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryptor.
// Contents: FSM state encoding, round count, initial round constant,
// the forward S-box and the GF(2^8) xtime helper (polynomial 0x11b).
package aes_pkg;

  localparam int unsigned NR       = 10;
  localparam logic [7:0]  RconInit = 8'h01;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StFinal = 2'd2,
    StDone  = 2'd3
  } aes_state_e;

  localparam logic [7:0] SboxTable [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_sequencer_if.sv
// Handshake bundle of the AES-128 encryption sequencer.
//   in_valid/in_ready   : plaintext/key acceptance handshake
//   plaintext/key       : 128-bit inputs, byte 0 in [127:120], column-major
//   out_valid/out_ready : ciphertext delivery handshake
//   ciphertext          : 128-bit result, same byte order
//   busy                : encryption rounds in progress
// slave = the sequencer, master = the producer/consumer driving it.
interface aes_enc_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_round_comb.sv
// One combinational AES-128 encryption round plus one key-schedule step.
//   i_state : current state (byte 0 in [127:120], column-major)
//   i_rkey  : previous round key
//   i_rcon  : round constant for this step
//   i_final : skip MixColumns (last round)
//   o_state : SubBytes/ShiftRows/(MixColumns)/AddRoundKey(o_key) result
//   o_key   : next round key
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic [7:0]   i_rcon,
  input  logic         i_final,
  output logic [127:0] o_state,
  output logic [127:0] o_key
);

  logic [7:0]   w_sr [16];
  logic [127:0] w_cols;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_k0;
  logic [31:0]  w_k1;
  logic [31:0]  w_k2;
  logic [31:0]  w_k3;

  for (genvar c = 0; c < 4; c++) begin : g_col
    // SubBytes and ShiftRows merged: row r of column c takes the byte from column (c+r)%4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[c*4+r] = sbox(i_state[127-8*(((c+r)%4)*4+r) -: 8]);
    end

    logic [7:0]  w_a0;
    logic [7:0]  w_a1;
    logic [7:0]  w_a2;
    logic [7:0]  w_a3;
    logic [31:0] w_mc;

    assign w_a0 = w_sr[c*4+0];
    assign w_a1 = w_sr[c*4+1];
    assign w_a2 = w_sr[c*4+2];
    assign w_a3 = w_sr[c*4+3];

    assign w_mc = {xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
                   w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
                   w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
                   xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)};

    assign w_cols[127-32*c -: 32] = i_final ? {w_a0, w_a1, w_a2, w_a3} : w_mc;
  end

  // Key schedule: RotWord/SubWord on word 3, rcon into the top byte, then chain-XOR.
  assign w_rot = {i_rkey[23:0], i_rkey[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_k0  = i_rkey[127:96] ^ w_sub ^ {i_rcon, 24'h000000};
  assign w_k1  = i_rkey[95:64] ^ w_k0;
  assign w_k2  = i_rkey[63:32] ^ w_k1;
  assign w_k3  = i_rkey[31:0] ^ w_k2;

  assign o_key   = {w_k0, w_k1, w_k2, w_k3};
  assign o_state = w_cols ^ o_key;

endmodule

// File: rtl/aes_enc_sequencer.sv
// Iterative AES-128 encryption controller: one shared round datapath
// reused ten times with on-the-fly round keys.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : aes_enc_sequencer_if.slave (input/output handshakes, busy)
// Accept at edge 0, rounds at edges 1..10, out_valid visible after edge 10.
module aes_enc_sequencer
  import aes_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  aes_enc_sequencer_if.slave  bus
);

  aes_state_e   r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rkey;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [127:0] r_ciphertext;

  logic [127:0] w_next_state;
  logic [127:0] w_next_key;
  logic         w_final;

  assign w_final = (r_fsm == StFinal);

  aes_round_comb u_round (
    .i_state (r_state),
    .i_rkey  (r_rkey),
    .i_rcon  (r_rcon),
    .i_final (w_final),
    .o_state (w_next_state),
    .o_key   (w_next_key)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm        <= StIdle;
      r_state      <= '0;
      r_rkey       <= '0;
      r_rcon       <= RconInit;
      r_rnd        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_ciphertext <= '0;
    end else begin
      case (r_fsm)
        StIdle: begin
          if (bus.in_valid && r_in_ready) begin
            r_state    <= bus.plaintext ^ bus.key;
            r_rkey     <= bus.key;
            r_rcon     <= RconInit;
            r_rnd      <= 4'd1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= StRound;
          end
        end
        StRound: begin
          r_state <= w_next_state;
          r_rkey  <= w_next_key;
          r_rcon  <= xtime(r_rcon);
          r_rnd   <= r_rnd + 4'd1;
          if (r_rnd == 4'(NR - 1)) begin
            r_fsm <= StFinal;
          end
        end
        StFinal: begin
          r_state      <= w_next_state;
          r_rkey       <= w_next_key;
          r_rcon       <= xtime(r_rcon);
          r_rnd        <= r_rnd + 4'd1;
          r_ciphertext <= w_next_state;
          r_out_valid  <= 1'b1;
          r_busy       <= 1'b0;
          r_fsm        <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= StIdle;
          end
        end
        default: r_fsm <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.ciphertext = r_ciphertext;

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Self-checking bench for aes_enc_sequencer: FIPS-197 known answers,
// backpressure, back-to-back throughput, mid-round reset and randomized
// blocks against a reference AES-128 model with an expanded key schedule.
module tb_aes_enc_sequencer;

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BR1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] m_sbox [256];

  aes_enc_sequencer_if bus ();

  aes_enc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] x = b;
    for (int i = 0; i < n; i++) x = {x[6:0], x[7]};
    return x;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tmp;
    logic [127:0] res = '0;
    for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (120 - 8 * i));
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = m_sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) s[c*4+r] = t[((c + r) % 4) * 4 + r];
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) t[r] = s[c*4+r];
            for (int r = 0; r < 4; r++)
              s[c*4+r] = gmul(t[r], 8'h02) ^ gmul(t[(r+1)%4], 8'h03) ^ t[(r+2)%4] ^ t[(r+3)%4];
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[c*4+r] = s[c*4+r] ^ 8'(w[rnd*4+c] >> (24 - 8 * r));
    end
    for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk1({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk128({tag, "_ciphertext"}, bus.ciphertext, 128'h0);
  endtask

  // Offers one pair, waits for out_valid; leaves the DUT in DONE.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input bit scramble,
                           input bit chk_r1, input logic [127:0] r1,
                           output logic [127:0] ct, output int lat);
    bit seen = 1'b0;
    lat = 0;
    ct  = '0;
    chk1("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk1("busy_after_accept", bus.busy, 1'b1);
    chk1("in_ready_after_accept", bus.in_ready, 1'b0);
    for (int i = 1; i <= 30 && !seen; i++) begin
      if (scramble) begin
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
        bus.key       = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      if (chk_r1 && i == 1) chk128("round1_state", dut.r_state, r1);
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = i;
        ct   = bus.ciphertext;
      end
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL out_valid_timeout: observed none expected out_valid within 30 cycles");
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk1("drain_out_valid", bus.out_valid, 1'b0);
    chk1("drain_in_ready", bus.in_ready, 1'b1);
    chk1("drain_busy", bus.busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] k;
    logic [127:0] out_ct [2];
    int           acc_t [2];
    int           lat;
    int           acc_cnt;
    int           outs;
    int           cyc;
    bit           acc;
    bit           seen_ov;

    build_sbox();
    chk128("model_c1", aes_model(C1Pt, C1Key), C1Ct);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    rst           = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset");
    chkn("reset_rnd", int'(dut.r_rnd), 0);
    chk128("reset_rcon", {120'h0, dut.r_rcon}, 128'h01);

    // First accept on the first edge with rst high.
    rst = 1'b1;
    run_block(C1Pt, C1Key, 1'b0, 1'b0, '0, ct, lat);
    chk128("c1_ct", ct, C1Ct);
    chkn("c1_latency", lat, 10);
    drain();

    // FIPS-197 B with round-1 state, then 20 cycles of backpressure.
    run_block(BPt, BKey, 1'b0, 1'b1, BR1, ct, lat);
    chk128("b_ct", ct, BCt);
    chkn("b_latency", lat, 10);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      bus.key       = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk128("bp_ciphertext", bus.ciphertext, BCt);
      chk1("bp_out_valid", bus.out_valid, 1'b1);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    drain();
    repeat (2) step();
    chk1("bp_not_accepted", bus.busy, 1'b0);

    // Back-to-back: in_valid held high, C.1 then B.
    bus.out_ready = 1'b1;
    bus.plaintext = C1Pt;
    bus.key       = C1Key;
    bus.in_valid  = 1'b1;
    acc_cnt = 0;
    outs    = 0;
    cyc     = 0;
    while (outs < 2 && cyc < 60) begin
      acc = bus.in_valid && bus.in_ready;
      step();
      cyc++;
      if (acc && acc_cnt < 2) begin
        acc_t[acc_cnt] = cyc;
        acc_cnt++;
        if (acc_cnt == 1) begin
          bus.plaintext = BPt;
          bus.key       = BKey;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        out_ct[outs] = bus.ciphertext;
        outs++;
      end
    end
    bus.in_valid = 1'b0;
    chkn("b2b_outputs", outs, 2);
    chkn("b2b_accepts", acc_cnt, 2);
    if (acc_cnt == 2) chkn("b2b_accept_spacing", acc_t[1] - acc_t[0], 12);
    if (outs == 2) begin
      chk128("b2b_ct0", out_ct[0], C1Ct);
      chk128("b2b_ct1", out_ct[1], BCt);
    end
    step();
    bus.out_ready = 1'b0;
    step();
    chk1("b2b_idle_in_ready", bus.in_ready, 1'b1);

    // Reset asserted while round 5 is pending.
    bus.plaintext = C1Pt;
    bus.key       = C1Key;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chkn("pre_reset_rnd", int'(dut.r_rnd), 5);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    chkn("midrst_rnd", int'(dut.r_rnd), 0);
    chk128("midrst_state", dut.r_state, 128'h0);
    seen_ov = 1'b0;
    repeat (2) begin
      step();
      if (bus.out_valid) seen_ov = 1'b1;
    end
    rst = 1'b1;
    repeat (15) begin
      step();
      if (bus.out_valid) seen_ov = 1'b1;
    end
    chk1("midrst_no_out_valid", seen_ov, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    run_block(C1Pt, C1Key, 1'b0, 1'b0, '0, ct, lat);
    chk128("post_rst_c1_ct", ct, C1Ct);
    chkn("post_rst_latency", lat, 10);
    drain();

    // Random pairs, inputs scrambled every cycle after accept.
    for (int n = 0; n < 4; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = 1'(n % 2);
      run_block(pt, k, 1'b1, 1'b0, '0, ct, lat);
      chk128("rand_ct", ct, aes_model(pt, k));
      chkn("rand_latency", lat, 10);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
